// File: rtl/hyperbus_w2phy.sv
// Write-direction splitter: breaks buffered AXI W beats into PHY-width words
// with per-byte masks for narrow, unaligned and full-width bursts.
module hyperbus_w2phy #(
  parameter int AxiDataWidth = 64,
  parameter int NumPhys      = 2,
  parameter int BurstLength  = 8,
  parameter int AddrWidth    = $clog2(AxiDataWidth/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      trans_handshake_i,
  input  logic                      is_a_write_i,
  input  logic [AddrWidth-1:0]      start_addr_i,
  input  logic [2:0]                size_i,
  input  logic [BurstLength-1:0]    burst_len_i,
  input  logic                      axi_valid_i,
  output logic                      axi_ready_o,
  input  logic [AxiDataWidth-1:0]   axi_data_i,
  input  logic [AxiDataWidth/8-1:0] axi_strb_i,
  input  logic                      axi_last_i,
  output logic                      phy_valid_o,
  input  logic                      phy_ready_i,
  output logic [16*NumPhys-1:0]     phy_data_o,
  output logic [2*NumPhys-1:0]      phy_mask_o,
  output logic                      phy_last_o,
  output logic                      len_error_o
);

  localparam int PhyWidth     = 16*NumPhys;
  localparam int NumPhyBytes  = 2*NumPhys;
  localparam int BusBytes     = AxiDataWidth/8;
  localparam int WordsPerBeat = BusBytes/NumPhyBytes;
  localparam int NpbLog       = $clog2(NumPhyBytes);
  localparam int IdxW         = (WordsPerBeat > 1) ? $clog2(WordsPerBeat) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_AXI = 2'd1,
    EMIT     = 2'd2
  } state_e;

  state_e                    state_r, state_s;
  logic [2:0]                size_r;
  logic [BurstLength-1:0]    len_r;
  logic [BurstLength-1:0]    beat_cnt_r;
  logic [AddrWidth-1:0]      byte_addr_r;
  logic [AxiDataWidth-1:0]   data_buf_r;
  logic [BusBytes-1:0]       strb_buf_r;
  logic                      last_buf_r;
  logic [IdxW-1:0]           word_idx_r;
  logic                      len_error_r;

  logic [AddrWidth-1:0]      aligned_s;
  logic [AddrWidth:0]        beat_bytes_s;
  logic [AddrWidth:0]        win_end_s;
  logic [IdxW-1:0]           first_idx_s;
  logic [IdxW-1:0]           last_idx_s;
  logic                      final_word_s;
  logic [AddrWidth-1:0]      next_addr_s;
  logic [NumPhyBytes-1:0]    lane_mask_s;
  logic [AddrWidth:0]        lane_s;
  logic                      emit_s;

  // Beat window geometry derived from the current lane and size.
  always_comb begin
    aligned_s    = (byte_addr_r >> size_r) << size_r;
    beat_bytes_s = {{AddrWidth{1'b0}}, 1'b1} << size_r;
    win_end_s    = {1'b0, aligned_s} + beat_bytes_s;
    first_idx_s  = IdxW'(byte_addr_r >> NpbLog);
    last_idx_s   = IdxW'((win_end_s - {{AddrWidth{1'b0}}, 1'b1}) >> NpbLog);
    final_word_s = (word_idx_r == last_idx_s);
    // Truncation wraps the lane back to the start of the bus word.
    next_addr_s  = AddrWidth'(win_end_s);
  end

  // Per-byte in-window mask for the word currently presented.
  always_comb begin
    lane_mask_s = {NumPhyBytes{1'b0}};
    lane_s      = {(AddrWidth+1){1'b0}};
    for (int j = 0; j < NumPhyBytes; j++) begin
      lane_s         = (AddrWidth+1)'(int'(word_idx_r) * NumPhyBytes + j);
      lane_mask_s[j] = (lane_s >= {1'b0, byte_addr_r}) && (lane_s < win_end_s);
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (trans_handshake_i && is_a_write_i) state_s = WAIT_AXI;
        else                                   state_s = IDLE;
      end
      WAIT_AXI: begin
        if (axi_valid_i) state_s = EMIT;
        else             state_s = WAIT_AXI;
      end
      EMIT: begin
        if (phy_ready_i && final_word_s) state_s = last_buf_r ? IDLE : WAIT_AXI;
        else                             state_s = EMIT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Transaction context, beat buffer and word/beat counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      size_r      <= 3'd0;
      len_r       <= {BurstLength{1'b0}};
      beat_cnt_r  <= {BurstLength{1'b0}};
      byte_addr_r <= {AddrWidth{1'b0}};
      data_buf_r  <= {AxiDataWidth{1'b0}};
      strb_buf_r  <= {BusBytes{1'b0}};
      last_buf_r  <= 1'b0;
      word_idx_r  <= {IdxW{1'b0}};
      len_error_r <= 1'b0;
    end else begin
      len_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (trans_handshake_i && is_a_write_i) begin
            size_r      <= size_i;
            len_r       <= burst_len_i;
            byte_addr_r <= start_addr_i;
            beat_cnt_r  <= {BurstLength{1'b0}};
          end
        end
        WAIT_AXI: begin
          if (axi_valid_i) begin
            data_buf_r  <= axi_data_i;
            strb_buf_r  <= axi_strb_i;
            last_buf_r  <= axi_last_i;
            word_idx_r  <= first_idx_s;
            len_error_r <= axi_last_i ? (beat_cnt_r != len_r) : (beat_cnt_r == len_r);
          end
        end
        EMIT: begin
          if (phy_ready_i) begin
            if (final_word_s) begin
              byte_addr_r <= next_addr_s;
              beat_cnt_r  <= beat_cnt_r + BurstLength'(1);
            end else begin
              word_idx_r  <= word_idx_r + IdxW'(1);
            end
          end
        end
        default: begin
          last_buf_r <= 1'b0;
        end
      endcase
    end
  end

  assign emit_s      = (state_r == EMIT);
  assign axi_ready_o = (state_r == WAIT_AXI);
  assign phy_valid_o = emit_s;
  assign phy_data_o  = emit_s ? data_buf_r[int'(word_idx_r)*PhyWidth +: PhyWidth]
                              : {PhyWidth{1'b0}};
  assign phy_mask_o  = emit_s ? (strb_buf_r[int'(word_idx_r)*NumPhyBytes +: NumPhyBytes] & lane_mask_s)
                              : {NumPhyBytes{1'b0}};
  assign phy_last_o  = emit_s & last_buf_r & final_word_s;
  assign len_error_o = len_error_r;

endmodule

// File: tb/tb_hyperbus_w2phy.sv
// Directed table-driven bench for hyperbus_w2phy (64-bit AXI, two PHYs).
module tb_hyperbus_w2phy;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trans_handshake_i;
  logic        is_a_write_i;
  logic [2:0]  start_addr_i;
  logic [2:0]  size_i;
  logic [7:0]  burst_len_i;
  logic        axi_valid_i;
  logic        axi_ready_o;
  logic [63:0] axi_data_i;
  logic [7:0]  axi_strb_i;
  logic        axi_last_i;
  logic        phy_valid_o;
  logic        phy_ready_i;
  logic [31:0] phy_data_o;
  logic [3:0]  phy_mask_o;
  logic        phy_last_o;
  logic        len_error_o;

  int checks   = 0;
  int failures = 0;

  hyperbus_w2phy #(.AxiDataWidth(64), .NumPhys(2), .BurstLength(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .trans_handshake_i(trans_handshake_i), .is_a_write_i(is_a_write_i),
    .start_addr_i(start_addr_i), .size_i(size_i), .burst_len_i(burst_len_i),
    .axi_valid_i(axi_valid_i), .axi_ready_o(axi_ready_o), .axi_data_i(axi_data_i),
    .axi_strb_i(axi_strb_i), .axi_last_i(axi_last_i),
    .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready_i), .phy_data_o(phy_data_o),
    .phy_mask_o(phy_mask_o), .phy_last_o(phy_last_o), .len_error_o(len_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic            start;
    logic [2:0]      size;
    logic [2:0]      addr;
    logic [7:0]      len;
    logic [63:0]     data;
    logic [7:0]      strb;
    logic            last;
    int              nw;
    logic [1:0][31:0] d;
    logic [1:0][3:0]  m;
    logic            lerr;
  } vec_t;

  localparam int NV = 12;
  vec_t v [NV];

  function automatic vec_t mk(logic st, logic [2:0] sz, logic [2:0] ad, logic [7:0] ln,
                              logic [63:0] dt, logic [7:0] sb, logic lst, int nw,
                              logic [31:0] d0, logic [3:0] m0, logic [31:0] d1,
                              logic [3:0] m1, logic le);
    vec_t r;
    r.start = st; r.size = sz; r.addr = ad; r.len = ln; r.data = dt; r.strb = sb;
    r.last = lst; r.nw = nw; r.d[0] = d0; r.m[0] = m0; r.d[1] = d1; r.m[1] = m1;
    r.lerr = le;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic aw(logic [2:0] sz, logic [2:0] ad, logic [7:0] ln);
    trans_handshake_i = 1'b1; is_a_write_i = 1'b1;
    size_i = sz; start_addr_i = ad; burst_len_i = ln;
    step();
    trans_handshake_i = 1'b0; is_a_write_i = 1'b0;
  endtask

  task automatic wait_ready(string name);
    int n = 0;
    while (!axi_ready_o && n < 10) begin
      step();
      n++;
    end
    chk(name, axi_ready_o, 1'b1);
  endtask

  task automatic beat(logic [63:0] dt, logic [7:0] sb, logic lst);
    axi_valid_i = 1'b1; axi_data_i = dt; axi_strb_i = sb; axi_last_i = lst;
    step();
    axi_valid_i = 1'b0; axi_last_i = 1'b0;
  endtask

  task automatic chk_idle_outputs(string name);
    chk({name, "_valid"}, phy_valid_o, 1'b0);
    chk({name, "_ready"}, axi_ready_o, 1'b0);
    chk({name, "_data"},  phy_data_o,  32'h0);
    chk({name, "_mask"},  phy_mask_o,  4'h0);
    chk({name, "_last"},  phy_last_o,  1'b0);
    chk({name, "_lerr"},  len_error_o, 1'b0);
  endtask

  initial begin
    //   start sz  addr len  data                   strb   last nw  d0            m0    d1            m1    lerr
    v[0]  = mk(1, 3'd3, 3'd0, 8'd1, 64'h1122334455667788, 8'hFF, 0, 2, 32'h55667788, 4'hF, 32'h11223344, 4'hF, 0);
    v[1]  = mk(0, 3'd3, 3'd0, 8'd1, 64'h99AABBCCDDEEFF00, 8'hFF, 1, 2, 32'hDDEEFF00, 4'hF, 32'h99AABBCC, 4'hF, 0);
    v[2]  = mk(1, 3'd1, 3'd6, 8'd1, 64'h0123456789ABCDEF, 8'hFF, 0, 1, 32'h01234567, 4'hC, 32'h0,        4'h0, 0);
    v[3]  = mk(0, 3'd1, 3'd6, 8'd1, 64'hFEDCBA9876543210, 8'hFF, 1, 1, 32'h76543210, 4'h3, 32'h0,        4'h0, 0);
    v[4]  = mk(1, 3'd3, 3'd5, 8'd1, 64'hA1A2A3A4B1B2B3B4, 8'hFF, 0, 1, 32'hA1A2A3A4, 4'hE, 32'h0,        4'h0, 0);
    v[5]  = mk(0, 3'd3, 3'd5, 8'd1, 64'hC1C2C3C4D1D2D3D4, 8'hFF, 1, 2, 32'hD1D2D3D4, 4'hF, 32'hC1C2C3C4, 4'hF, 0);
    v[6]  = mk(1, 3'd3, 3'd0, 8'd0, 64'h5555AAAA0F0F0F0F, 8'h0F, 1, 2, 32'h0F0F0F0F, 4'hF, 32'h5555AAAA, 4'h0, 0);
    v[7]  = mk(1, 3'd3, 3'd0, 8'd2, 64'h0102030405060708, 8'hFF, 0, 2, 32'h05060708, 4'hF, 32'h01020304, 4'hF, 0);
    v[8]  = mk(0, 3'd3, 3'd0, 8'd2, 64'h1112131415161718, 8'hFF, 1, 2, 32'h15161718, 4'hF, 32'h11121314, 4'hF, 1);
    v[9]  = mk(1, 3'd2, 3'd4, 8'd1, 64'h1234567800000000, 8'hFF, 1, 1, 32'h12345678, 4'hF, 32'h0,        4'h0, 1);
    v[10] = mk(1, 3'd0, 3'd3, 8'd0, 64'h00000000AABBCCDD, 8'hFF, 0, 1, 32'hAABBCCDD, 4'h8, 32'h0,        4'h0, 1);
    v[11] = mk(0, 3'd0, 3'd3, 8'd0, 64'h5566778800000000, 8'hFF, 1, 1, 32'h55667788, 4'h1, 32'h0,        4'h0, 1);

    rst_i = 1'b1; trans_handshake_i = 1'b0; is_a_write_i = 1'b0;
    start_addr_i = 3'd0; size_i = 3'd0; burst_len_i = 8'd0;
    axi_valid_i = 1'b0; axi_data_i = 64'h0; axi_strb_i = 8'h0; axi_last_i = 1'b0;
    phy_ready_i = 1'b1;
    step(); step();
    chk_idle_outputs("reset");
    rst_i = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      if (v[i].start) aw(v[i].size, v[i].addr, v[i].len);
      wait_ready($sformatf("v%0d_ready", i));
      beat(v[i].data, v[i].strb, v[i].last);
      for (int k = 0; k < v[i].nw; k++) begin
        chk($sformatf("v%0d_w%0d_valid", i, k), phy_valid_o, 1'b1);
        chk($sformatf("v%0d_w%0d_data", i, k),  phy_data_o, v[i].d[k]);
        chk($sformatf("v%0d_w%0d_mask", i, k),  phy_mask_o, v[i].m[k]);
        chk($sformatf("v%0d_w%0d_last", i, k),  phy_last_o, (k == v[i].nw - 1) && v[i].last);
        chk($sformatf("v%0d_w%0d_lerr", i, k),  len_error_o, (k == 0) ? v[i].lerr : 1'b0);
        chk($sformatf("v%0d_w%0d_axrdy", i, k), axi_ready_o, 1'b0);
        step();
      end
      chk($sformatf("v%0d_after_valid", i), phy_valid_o, 1'b0);
      chk($sformatf("v%0d_after_axrdy", i), axi_ready_o, !v[i].last);
    end

    // Backpressure: stall the first word for three cycles, then resume.
    aw(3'd3, 3'd0, 8'd0);
    wait_ready("bp_ready");
    beat(64'h8877665544332211, 8'hFF, 1'b1);
    phy_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_stall%0d_valid", c), phy_valid_o, 1'b1);
      chk($sformatf("bp_stall%0d_data", c),  phy_data_o, 32'h44332211);
      chk($sformatf("bp_stall%0d_mask", c),  phy_mask_o, 4'hF);
      chk($sformatf("bp_stall%0d_last", c),  phy_last_o, 1'b0);
      chk($sformatf("bp_stall%0d_axrdy", c), axi_ready_o, 1'b0);
      step();
    end
    phy_ready_i = 1'b1;
    chk("bp_release_data", phy_data_o, 32'h44332211);
    step();
    chk("bp_w1_valid", phy_valid_o, 1'b1);
    chk("bp_w1_data",  phy_data_o, 32'h88776655);
    chk("bp_w1_last",  phy_last_o, 1'b1);
    step();
    chk("bp_done_valid", phy_valid_o, 1'b0);

    // Reset asserted while a word is being presented.
    aw(3'd3, 3'd0, 8'd0);
    wait_ready("rst_ready");
    beat(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
    phy_ready_i = 1'b0;
    chk("rst_pre_valid", phy_valid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    @(negedge clk_i);
    rst_i = 1'b0;
    phy_ready_i = 1'b1;
    step();
    chk_idle_outputs("rst_after");

    // Normal operation resumes after the mid-burst reset.
    aw(3'd2, 3'd0, 8'd0);
    wait_ready("post_ready");
    beat(64'h0000000013579BDF, 8'hFF, 1'b1);
    chk("post_valid", phy_valid_o, 1'b1);
    chk("post_data",  phy_data_o, 32'h13579BDF);
    chk("post_mask",  phy_mask_o, 4'hF);
    chk("post_last",  phy_last_o, 1'b1);
    step();
    chk("post_done_valid", phy_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
